// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window generator and its line buffers.
package sobel_pkg;
  localparam int DATA_SIZE_DEF  = 24;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = cnt_w(IMG_WIDTH_DEF);
  localparam int ROW_W_DEF = cnt_w(IMG_HEIGHT_DEF);
endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: combinational read of addr, write on clk; a same-cycle
// write lands after the read, so dout always shows the previous line's pixel.
module sobel_line_buffer #(
  parameter int depth = 640,
  parameter int width = 24,
  parameter int aw    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    addr,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);
  logic [width-1:0] r_mem [depth];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= din;
  end

  assign dout = r_mem[addr];
endmodule

// File: rtl/sobel_window_gen.sv
// Builds 3x3 windows from a raster pixel stream; taps/valid_data 1 cycle after the
// completing beat. pix_ready only in FILL/STREAM; stalls freeze the window.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int data_size  = DATA_SIZE_DEF,
  parameter int img_width  = IMG_WIDTH_DEF,
  parameter int img_height = IMG_HEIGHT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [data_size-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 valid_data,
  output logic [data_size-1:0] in_p1a_x,
  output logic [data_size-1:0] in_p2_x,
  output logic [data_size-1:0] in_p1b_x,
  output logic [data_size-1:0] in_m1a_x,
  output logic [data_size-1:0] in_m2_x,
  output logic [data_size-1:0] in_m1b_x,
  output logic [data_size-1:0] in_p1a_y,
  output logic [data_size-1:0] in_p2_y,
  output logic [data_size-1:0] in_p1b_y,
  output logic [data_size-1:0] in_m1a_y,
  output logic [data_size-1:0] in_m2_y,
  output logic [data_size-1:0] in_m1b_y,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int CW = cnt_w(img_width);
  localparam int RW = cnt_w(img_height);
  localparam logic [CW-1:0] COL_LAST = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(img_height - 1);

  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic w_fire, w_col_last, w_frame_last, w_win;
  logic [data_size-1:0] w_lb0_dout, w_lb1_dout;
  // Two most recent columns per row; the newest column comes live from lb1/lb0/pix_in.
  logic [data_size-1:0] r_top0, r_top1, r_mid0, r_mid1, r_bot0, r_bot1;
  logic [data_size-1:0] r_p1a_x, r_p2_x, r_p1b_x, r_m1a_x, r_m2_x, r_m1b_x;
  logic [data_size-1:0] r_p1a_y, r_p2_y, r_p1b_y, r_m1a_y, r_m2_y, r_m1b_y;
  logic r_valid;

  assign pix_ready    = (r_state == ST_FILL) || (r_state == ST_STREAM);
  assign busy         = pix_ready;
  assign frame_done   = (r_state == ST_DONE);
  assign w_fire       = pix_valid && pix_ready;
  assign w_col_last   = (r_col == COL_LAST);
  assign w_frame_last = w_col_last && (r_row == ROW_LAST);
  assign w_win        = w_fire && (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_FILL;
      ST_FILL:   if (w_fire && (r_row == RW'(2)) && (r_col == '0)) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_fire && w_frame_last) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_frame_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  sobel_line_buffer #(.depth(img_width), .width(data_size), .aw(CW)) u_lb0 (
    .clk(clk), .we(w_fire), .addr(r_col), .din(pix_in), .dout(w_lb0_dout)
  );

  sobel_line_buffer #(.depth(img_width), .width(data_size), .aw(CW)) u_lb1 (
    .clk(clk), .we(w_fire), .addr(r_col), .din(w_lb0_dout), .dout(w_lb1_dout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_top0, r_top1, r_mid0, r_mid1, r_bot0, r_bot1} <= '0;
      {r_p1a_x, r_p2_x, r_p1b_x, r_m1a_x, r_m2_x, r_m1b_x} <= '0;
      {r_p1a_y, r_p2_y, r_p1b_y, r_m1a_y, r_m2_y, r_m1b_y} <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_win;
      if (w_fire) begin
        r_top0 <= r_top1;  r_top1 <= w_lb1_dout;
        r_mid0 <= r_mid1;  r_mid1 <= w_lb0_dout;
        r_bot0 <= r_bot1;  r_bot1 <= pix_in;
      end
      if (w_win) begin
        r_p1a_x <= w_lb1_dout;  r_p2_x <= w_lb0_dout;  r_p1b_x <= pix_in;
        r_m1a_x <= r_top0;      r_m2_x <= r_mid0;      r_m1b_x <= r_bot0;
        r_p1a_y <= r_bot0;      r_p2_y <= r_bot1;      r_p1b_y <= pix_in;
        r_m1a_y <= r_top0;      r_m2_y <= r_top1;      r_m1b_y <= w_lb1_dout;
      end
    end
  end

  assign valid_data = r_valid;
  assign in_p1a_x = r_p1a_x;  assign in_p2_x = r_p2_x;  assign in_p1b_x = r_p1b_x;
  assign in_m1a_x = r_m1a_x;  assign in_m2_x = r_m2_x;  assign in_m1b_x = r_m1b_x;
  assign in_p1a_y = r_p1a_y;  assign in_p2_y = r_p2_y;  assign in_p1b_y = r_p1b_y;
  assign in_m1a_y = r_m1a_y;  assign in_m2_y = r_m2_y;  assign in_m1b_y = r_m1b_y;
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 and a 5x3 instance checked every cycle against an image-array model.
module tb_sobel_window_gen;
  localparam int DS = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, start, pv;
  logic [1:0][DS-1:0] pin;
  wire  [1:0] rdy, vd, bsy, fd;
  wire  [1:0][11:0][DS-1:0] tap;

  int total = 0;
  int bad = 0;
  int W[2], H[2];
  logic [DS-1:0] img[2][4][5];
  bit m_act[2], m_dn[2], exp_vld[2];
  logic [DS-1:0] exp_tap[2][12];
  logic [DS-1:0] first_tap[2][12];
  int m_n[2], win_cnt[2], fd_cnt[2];
  int mk_q[2][$];
  int exp_first[12];

  sobel_window_gen #(.data_size(DS), .img_width(4), .img_height(4)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .start(start[0]), .pix_in(pin[0]), .pix_valid(pv[0]),
    .pix_ready(rdy[0]), .valid_data(vd[0]),
    .in_p1a_x(tap[0][0]), .in_p2_x(tap[0][1]), .in_p1b_x(tap[0][2]),
    .in_m1a_x(tap[0][3]), .in_m2_x(tap[0][4]), .in_m1b_x(tap[0][5]),
    .in_p1a_y(tap[0][6]), .in_p2_y(tap[0][7]), .in_p1b_y(tap[0][8]),
    .in_m1a_y(tap[0][9]), .in_m2_y(tap[0][10]), .in_m1b_y(tap[0][11]),
    .busy(bsy[0]), .frame_done(fd[0])
  );

  sobel_window_gen #(.data_size(DS), .img_width(5), .img_height(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .start(start[1]), .pix_in(pin[1]), .pix_valid(pv[1]),
    .pix_ready(rdy[1]), .valid_data(vd[1]),
    .in_p1a_x(tap[1][0]), .in_p2_x(tap[1][1]), .in_p1b_x(tap[1][2]),
    .in_m1a_x(tap[1][3]), .in_m2_x(tap[1][4]), .in_m1b_x(tap[1][5]),
    .in_p1a_y(tap[1][6]), .in_p2_y(tap[1][7]), .in_p1b_y(tap[1][8]),
    .in_m1a_y(tap[1][9]), .in_m2_y(tap[1][10]), .in_m1b_y(tap[1][11]),
    .busy(bsy[1]), .frame_done(fd[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic model_clear(input int id);
    m_act[id] = 0; m_dn[id] = 0; m_n[id] = 0; exp_vld[id] = 0;
    for (int j = 0; j < 12; j++) exp_tap[id][j] = '0;
  endtask

  // Reference: store each accepted pixel at (n/W, n%W); a window exists when both >= 2.
  task automatic model_step(input int id);
    bit acc, last;
    int r, c;
    if (!rst_n[id]) begin
      model_clear(id);
      return;
    end
    acc = m_act[id] && pv[id];
    last = 0;
    exp_vld[id] = 0;
    if (acc) begin
      r = m_n[id] / W[id];
      c = m_n[id] % W[id];
      img[id][r][c] = pin[id];
      if (r >= 2 && c >= 2) begin
        exp_vld[id] = 1;
        exp_tap[id][0]  = img[id][r-2][c];   exp_tap[id][1]  = img[id][r-1][c];
        exp_tap[id][2]  = img[id][r][c];     exp_tap[id][3]  = img[id][r-2][c-2];
        exp_tap[id][4]  = img[id][r-1][c-2]; exp_tap[id][5]  = img[id][r][c-2];
        exp_tap[id][6]  = img[id][r][c-2];   exp_tap[id][7]  = img[id][r][c-1];
        exp_tap[id][8]  = img[id][r][c];     exp_tap[id][9]  = img[id][r-2][c-2];
        exp_tap[id][10] = img[id][r-2][c-1]; exp_tap[id][11] = img[id][r-2][c];
        mk_q[id].push_back(int'(pin[id]));
      end
      last = (m_n[id] == W[id] * H[id] - 1);
      m_n[id]++;
    end
    if (m_dn[id]) begin
      m_dn[id] = 0;
      m_act[id] = 0;
    end else if (!m_act[id]) begin
      if (start[id]) begin
        m_act[id] = 1;
        m_n[id] = 0;
      end
    end else if (last) begin
      m_act[id] = 0;
      m_dn[id] = 1;
    end
  endtask

  task automatic check(input int id);
    if (!rst_n[id]) model_clear(id);
    chk($sformatf("d%0d_ready", id), 32'(rdy[id]), 32'(m_act[id]));
    chk($sformatf("d%0d_busy", id), 32'(bsy[id]), 32'(m_act[id]));
    chk($sformatf("d%0d_frame_done", id), 32'(fd[id]), 32'(m_dn[id]));
    chk($sformatf("d%0d_valid", id), 32'(vd[id]), 32'(exp_vld[id]));
    for (int j = 0; j < 12; j++)
      chk($sformatf("d%0d_tap%0d", id, j), 32'(tap[id][j]), 32'(exp_tap[id][j]));
    if (vd[id] === 1'b1) begin
      if (win_cnt[id] == 0)
        for (int j = 0; j < 12; j++) first_tap[id][j] = tap[id][j];
      win_cnt[id]++;
    end
    if (fd[id] === 1'b1) fd_cnt[id]++;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    check(0);
    check(1);
  end

  task automatic clear_stats(input int id);
    win_cnt[id] = 0;
    fd_cnt[id] = 0;
    mk_q[id].delete();
  endtask

  task automatic send_frame(input int id, input int base, input int gap_after, input int gap_len,
                            input bit rnd, input int start_at, input int stop_at);
    int n_pix, k, gap, cyc;
    n_pix = W[id] * H[id];
    k = 0; gap = 0; cyc = 0;
    @(negedge clk); #1; start[id] = 1'b1;
    @(negedge clk); #1; start[id] = 1'b0;
    while (k < n_pix && k != stop_at && cyc < 500) begin
      start[id] = (k == start_at);
      if (gap > 0) begin
        pv[id] = 1'b0;
        gap--;
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        pv[id] = 1'b0;
      end else begin
        pv[id] = 1'b1;
        pin[id] = rnd ? DS'($urandom()) : DS'(base + k);
      end
      if (pv[id] && rdy[id]) begin
        if (k == gap_after) gap = gap_len;
        k++;
      end
      @(negedge clk); #1;
      cyc++;
    end
    pv[id] = 1'b0;
    start[id] = 1'b0;
    if (stop_at < 0) chk($sformatf("d%0d_beats", id), 32'(k), 32'(n_pix));
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic chk_first(input string nm);
    for (int j = 0; j < 12; j++)
      chk($sformatf("%s_tap%0d", nm, j), 32'(first_tap[0][j]), 32'(exp_first[j]));
  endtask

  task automatic chk_ks(input int id, input string nm, input int a, input int b, input int c, input int d);
    int want[$];
    want = {a, b, c};
    if (d >= 0) want.push_back(d);
    chk({nm, "_nwin"}, 32'(mk_q[id].size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < mk_q[id].size(); i++)
      chk($sformatf("%s_k%0d", nm, i), 32'(mk_q[id][i]), 32'(want[i]));
  endtask

  initial begin
    W[0] = 4; H[0] = 4; W[1] = 5; H[1] = 3;
    exp_first = '{2, 6, 10, 0, 4, 8, 8, 9, 10, 0, 1, 2};
    rst_n = 2'b00; start = 2'b00; pv = 2'b00; pin = '0;
    model_clear(0); model_clear(1);
    clear_stats(0); clear_stats(1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(rdy[0]), 32'd0);
    chk("reset_valid", 32'(vd[0]), 32'd0);
    chk("reset_tap_p1a_x", 32'(tap[0][0]), 32'd0);
    chk("reset_busy1", 32'(bsy[1]), 32'd0);
    rst_n = 2'b11;
    settle();

    // Back-to-back 4x4 frame, pix_in = k
    clear_stats(0);
    send_frame(0, 0, -1, 0, 1'b0, -1, -1);
    settle();
    chk("a_nwin", 32'(win_cnt[0]), 32'd4);
    chk("a_frame_done", 32'(fd_cnt[0]), 32'd1);
    chk_ks(0, "a", 10, 11, 14, 15);
    chk_first("a_first");
    chk("a_last_p1a_x", 32'(tap[0][0]), 32'd7);
    chk("a_last_m1b_x", 32'(tap[0][5]), 32'd13);
    chk("a_idle_ready", 32'(rdy[0]), 32'd0);

    // Three-cycle gap after k=9
    clear_stats(0);
    send_frame(0, 0, 9, 3, 1'b0, -1, -1);
    settle();
    chk("b_nwin", 32'(win_cnt[0]), 32'd4);
    chk_first("b_first");

    // pix_valid with no start, then a stray start mid-frame
    clear_stats(0);
    @(negedge clk); #1;
    pv[0] = 1'b1; pin[0] = DS'(55);
    repeat (10) @(negedge clk);
    #1;
    chk("c_nostart_ready", 32'(rdy[0]), 32'd0);
    pv[0] = 1'b0;
    chk("c_nostart_nwin", 32'(win_cnt[0]), 32'd0);
    send_frame(0, 0, -1, 0, 1'b0, 5, -1);
    settle();
    chk("c_nwin", 32'(win_cnt[0]), 32'd4);
    chk_ks(0, "c", 10, 11, 14, 15);

    // Asynchronous reset after k=6, then a fresh frame with pix_in = 100+k
    send_frame(0, 0, -1, 0, 1'b0, -1, 7);
    @(posedge clk); #2;
    rst_n[0] = 1'b0;
    #1;
    chk("d_rst_ready", 32'(rdy[0]), 32'd0);
    chk("d_rst_busy", 32'(bsy[0]), 32'd0);
    chk("d_rst_valid", 32'(vd[0]), 32'd0);
    chk("d_rst_done", 32'(fd[0]), 32'd0);
    for (int j = 0; j < 12; j++) chk($sformatf("d_rst_tap%0d", j), 32'(tap[0][j]), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n[0] = 1'b1;
    clear_stats(0);
    send_frame(0, 100, -1, 0, 1'b0, -1, -1);
    settle();
    chk("d_nwin", 32'(win_cnt[0]), 32'd4);
    chk("d_first_m1a_x", 32'(first_tap[0][3]), 32'd100);
    chk("d_first_p1b_x", 32'(first_tap[0][2]), 32'd110);

    // 5x3 frame: windows only at cols >= 2 of the last line
    clear_stats(1);
    send_frame(1, 0, -1, 0, 1'b0, -1, -1);
    settle();
    chk("e_nwin", 32'(win_cnt[1]), 32'd3);
    chk("e_frame_done", 32'(fd_cnt[1]), 32'd1);
    chk_ks(1, "e", 12, 13, 14, -1);

    // Random pixels with random valid gaps on both instances
    for (int f = 0; f < 6; f++) begin
      clear_stats(f % 2);
      send_frame(f % 2, 0, -1, 0, 1'b1, -1, -1);
      settle();
      chk($sformatf("r%0d_nwin", f), 32'(win_cnt[f % 2]), 32'((W[f % 2] - 2) * (H[f % 2] - 2)));
      chk($sformatf("r%0d_frame_done", f), 32'(fd_cnt[f % 2]), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
